// File: rtl/loctag_reflect_seq_if.sv
// Signal bundle between trigger/mode control and the LocTag reflector sequencer.
// There is no valid/ready handshake here: all inputs are levels sampled on every clk edge, and all outputs are registered levels.
interface loctag_reflect_seq_if #(
  parameter int CHANNELS = 2
);
  logic                trig;
  logic [1:0]          mode;
  logic [1:0]          mac_q;
  logic [CHANNELS-1:0] ctrl;
  logic                busy;
  logic                led;
  logic [1:0]          state_dbg;

  modport master (
    output trig, mode, mac_q,
    input  ctrl, busy, led, state_dbg
  );

  modport slave (
    input  trig, mode, mac_q,
    output ctrl, busy, led, state_dbg
  );
endinterface

// File: rtl/loctag_reflect_seq.sv
// Trigger-timed, multi-channel LFSR chip-burst sequencer for the LocTag reflector switches.
// Optional build macro LOCTAG_RETRIG_EN: a trigger edge during a triggered burst restarts the delay.
module loctag_reflect_seq #(
  parameter int          CHANNELS               = 2,
  parameter int          TRIG_DELAY_IN_US       = 2,
  parameter int          TRIG_DELAY_IN_20NS_NEG = 25,
  parameter logic [15:0] MAC_SEED               = 16'h7654,
  parameter int          CHIP_CYCLES            = 25,
  parameter int          BURST_BITS             = 32,
  parameter int          GAP_CYCLES             = 500
) (
  input logic clk,
  input logic reset,
  loctag_reflect_seq_if.slave bus
);

  localparam int DELAY_CYCLES = TRIG_DELAY_IN_US * 50 - TRIG_DELAY_IN_20NS_NEG;
  localparam int CNT_MAX      = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam int CHIP_W       = $clog2(CHIP_CYCLES + 1);
  localparam int BIT_W        = $clog2(BURST_BITS + 1);

  localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CHIP_W-1:0] CHIP_LAST  = CHIP_W'(CHIP_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BURST_BITS - 1);
  localparam logic [15:0]       RST_SEED   = (MAC_SEED == 16'h0000) ? 16'h0001 : MAC_SEED;

  generate
    if (DELAY_CYCLES < 1 || CHANNELS < 1 || CHANNELS > 16 ||
        CHIP_CYCLES < 1 || BURST_BITS < 1 || GAP_CYCLES < 1) begin : g_param_check
      $error("loctag_reflect_seq: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DELAY, BURST, GAP} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [CHIP_W-1:0]   chip_cnt, chip_d;
  logic [BIT_W-1:0]    bit_cnt, bit_d;
  logic [15:0]         lfsr, lfsr_d, lfsr_shift, seed_raw, seed;
  logic [1:0]          mode_q;
  logic                sync1, sync2, sync3, trig_edge;
  logic [CHANNELS-1:0] ctrl_q, ctrl_d;
  logic                busy_q, led_q;

  // Synchroniser plus registered edge: sampled at T0, edge pulse after T2, acted on at T3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      sync1     <= bus.trig;
      sync2     <= sync1;
      sync3     <= sync2;
      trig_edge <= sync2 & ~sync3;
    end
  end

  assign seed_raw   = MAC_SEED ^ {14'b0, bus.mac_q};
  assign seed       = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;
  assign lfsr_shift = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    chip_d  = chip_cnt;
    bit_d   = bit_cnt;
    lfsr_d  = lfsr;
    ctrl_d  = '0;
    case (state)
      IDLE: begin
        if (bus.mode == 2'b10 && trig_edge) begin
          lfsr_d  = seed;
          cnt_d   = DELAY_LOAD;
          state_d = DELAY;
        end else if (bus.mode == 2'b11) begin
          lfsr_d  = seed;
          chip_d  = '0;
          bit_d   = '0;
          state_d = BURST;
        end
      end
      DELAY, GAP: begin
        if (cnt == '0) begin
          chip_d  = '0;
          bit_d   = '0;
          state_d = BURST;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      BURST: begin
`ifdef LOCTAG_RETRIG_EN
        if (bus.mode == 2'b10 && trig_edge) begin
          lfsr_d  = seed;
          cnt_d   = DELAY_LOAD;
          state_d = DELAY;
        end else
`endif
        if (chip_cnt == CHIP_LAST) begin
          chip_d = '0;
          lfsr_d = lfsr_shift;
          bit_d  = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_d   = '0;
            cnt_d   = GAP_LOAD;
            state_d = (bus.mode == 2'b11) ? GAP : IDLE;
          end
        end else begin
          chip_d = chip_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A mode change outside IDLE always wins and drops straight back to IDLE.
    if (state != IDLE && bus.mode != mode_q) state_d = IDLE;
    if (state_d == BURST)                            ctrl_d = lfsr_d[CHANNELS-1:0];
    else if (state_d == IDLE && bus.mode == 2'b01)   ctrl_d = '1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      chip_cnt <= '0;
      bit_cnt  <= '0;
      lfsr     <= RST_SEED;
      mode_q   <= 2'b00;
      ctrl_q   <= '0;
      busy_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      chip_cnt <= chip_d;
      bit_cnt  <= bit_d;
      lfsr     <= lfsr_d;
      mode_q   <= bus.mode;
      ctrl_q   <= ctrl_d;
      busy_q   <= (state_d != IDLE);
      led_q    <= (state_d == BURST);
    end
  end

  assign bus.ctrl      = ctrl_q;
  assign bus.busy      = busy_q;
  assign bus.led       = led_q;
  assign bus.state_dbg = state;

endmodule

// File: doc/loctag_reflect_seq.md
# loctag_reflect_seq

Multi-channel, trigger-timed reflector sequencer for LocTag. It supersedes the single `ctrl_1` reflector drive with a parametrised `CHANNELS`-wide control bus. It synchronises the detector trigger, waits a programmable delay, then emits a MAC-seeded pseudo-random chip burst on every reflector channel. It sits in the loctag core between trigger detection and the reflector switch pins.

## Interface
- `CHANNELS`, 2: number of reflector control outputs, 1..16.
- `TRIG_DELAY_IN_US`, 2: coarse trigger-to-burst delay in µs at the 50 MHz core clock.
- `TRIG_DELAY_IN_20NS_NEG`, 25: fine negative trim in 20 ns cycles. `DELAY_CYCLES = TRIG_DELAY_IN_US*50 - TRIG_DELAY_IN_20NS_NEG`, which must be ≥1. The default gives 75.
- `MAC_SEED`, 16'h7654: base LFSR seed.
- `CHIP_CYCLES`, 25: clock cycles per chip, ≥1.
- `BURST_BITS`, 32: chips per burst, ≥1.
- `GAP_CYCLES`, 500: idle cycles between bursts in free-run mode, ≥1.
- `clk` in 1: 50 MHz core clock.
- `reset` in 1: asynchronous, active-low reset.
- `trig` in 1: active-high trigger, asynchronous to `clk`.
- `mode` in 2: 00 off, 01 constant reflect, 10 triggered burst, 11 free-run.
- `mac_q` in 2: seed modifier.
- `ctrl` out CHANNELS: reflector switch drive.
- `busy` out 1: state ≠ IDLE.
- `led` out 1: high while in BURST.

## Operation
- Trigger path: 2-FF synchroniser, then rising-edge detector, giving a 1-cycle `trig_edge`.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left.
  - New bit 0 = b15^b13^b12^b10.
  - Seed = `MAC_SEED ^ {14'b0, mac_q}`, forced to 16'h0001 if the result is 0.
- Chip output: `ctrl[k] = lfsr[k]`. The LFSR shifts once per completed chip.
- FSM states: IDLE, DELAY, BURST, GAP.
  - IDLE: `ctrl` = 0 for mode 00/10/11 and all-ones for mode 01.
    - Mode 10 + `trig_edge`: load seed, load delay counter with `DELAY_CYCLES-1`, go to DELAY.
    - Mode 11: load seed, go to BURST directly.
  - DELAY: count down to 0, then go to BURST with the chip counter at 0 and the bit counter at 0.
  - BURST: `ctrl` shows the current chip. After `CHIP_CYCLES` cycles, shift the LFSR and increment the bit counter. After chip `BURST_BITS-1` completes:
    - mode 10: go to IDLE, `ctrl` = 0;
    - mode 11: go to GAP, `ctrl` = 0.
  - GAP: count `GAP_CYCLES`, then go to BURST. The LFSR continues and is not reseeded.
- Any change of `mode` while not in IDLE aborts to IDLE. `ctrl` takes the new mode's IDLE value on the next cycle.
- `trig_edge` in DELAY, GAP, or any mode other than 10 is ignored. `trig_edge` in BURST follows the Configuration section.
- Counter widths are sized with `$clog2` from the parameters; no wrap occurs within legal ranges.
- Illegal parameters (`DELAY_CYCLES` < 1, `CHANNELS` > 16) abort elaboration.

## Timing
- Reset values: state IDLE, `ctrl` = 0, `busy` = 0, `led` = 0, LFSR = seed, synchroniser = 0.
- Reset deassertion: internal logic is released on the first `clk` edge after deassertion. Reset asserted mid-burst forces `ctrl` to 0 immediately (asynchronously).
- Mode 10 latency: `trig` sampled high at edge T0 gives `trig_edge` at T2 and DELAY at T3. The first chip is on `ctrl` at T3+`DELAY_CYCLES`, which is 78 cycles by default.
- Burst length: `CHIP_CYCLES*BURST_BITS` cycles, 800 by default. `ctrl` returns to 0 one cycle after the last chip ends.
- All outputs are registered. `busy` and `led` change in the same cycle as the state.
- `trig` pulses must be ≥2 clock cycles wide to be guaranteed detection.

## Configuration
- `LOCTAG_RETRIG_EN` defined: `trig_edge` during BURST in mode 10 reloads the seed and the delay counter and enters DELAY. `ctrl` goes to 0 for the delay.
- `LOCTAG_RETRIG_EN` undefined: `trig_edge` during BURST is ignored and the burst completes unchanged.

## Test plan
- Reset held low, `trig` toggling, mode 10 → `ctrl`=0, `busy`=0, `led`=0 throughout; after release, no burst until a fresh edge.
- Mode 10, `mac_q`=01, `trig` high for 3 cycles → first chip `ctrl`=2'b01 (seed 0x7655) exactly 78 cycles after `trig` is sampled; 32 chips of 25 cycles each, matching the reference LFSR model; then `ctrl`=0, `busy`=0.
- Mode 01 → `ctrl`=2'b11 and `busy`=0; switch to 00 → `ctrl`=0 on the next cycle.
- Mode 11 → repeated 800-cycle bursts separated by 500-cycle gaps; the second burst continues the LFSR sequence rather than restarting at 0x7654.
- Mode 10, second `trig` edge mid-burst → with `LOCTAG_RETRIG_EN` the burst restarts 78 cycles later from the seed; without it the burst is unchanged and ends on schedule.
- Mode changed from 10 to 00 during DELAY and during BURST → IDLE next cycle, `ctrl`=0, `busy`=0, `led`=0.
